fifo_rd_stream: RTL

- Read-side drain engine for the MAC async FIFO. Runs in the read clock domain.
- Issues read enables against the FIFO empty flag and absorbs the one-cycle registered read latency of the FIFO RAM.
- Presents FIFO words to the TX datapath as a valid/ready stream with frame delimiting, using a last flag carried in the FIFO word MSB.
- Counts words per frame and reports length and oversize on each frame end.

---
 rtl/fifo_rd_stream_if.sv | 28 ++
 rtl/fifo_rd_stream.sv | 103 ++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_if.sv
// Read-side drain stream bundle: FIFO read port, output stream and frame report.
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned LEN_W = 11
);
  logic             fifo_empty;
  logic             fifo_r_en;
  logic [WIDTH-1:0] fifo_rdata;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-2:0] m_data;
  logic             m_last;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic             frame_oversize;

  // Drain engine side.
  modport master (
    input  fifo_empty, fifo_rdata, m_ready,
    output fifo_r_en, m_valid, m_data, m_last, frame_done, frame_len, frame_oversize
  );

  // FIFO plus downstream consumer side.
  modport slave (
    output fifo_empty, fifo_rdata, m_ready,
    input  fifo_r_en, m_valid, m_data, m_last, frame_done, frame_len, frame_oversize
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: pops the async FIFO, hides its one-cycle read latency behind a
// small output buffer, and streams words out with frame length / oversize reporting.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned LEN_W     = 11
) (
  input  logic              rclk,
  input  logic              rd_srst,
  fifo_rd_stream_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             inflight_q;
  logic [LEN_W-1:0] cnt_q;
  logic             sticky_q;
  logic             frame_done_q;
  logic [LEN_W-1:0] frame_len_q;
  logic             frame_oversize_q;

  logic             pop;
  logic [OCC_W:0]   level;
  logic [WIDTH-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Stream outputs from the buffer head; read enable keeps buffered + in-flight within depth.
  always_comb begin
    head               = buf_q[rd_ptr_q];
    bus.m_valid        = (occ_q != '0);
    bus.m_data         = head[WIDTH-2:0];
    bus.m_last         = head[WIDTH-1];
    pop                = bus.m_valid & bus.m_ready;
    level              = {1'b0, occ_q} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
    bus.fifo_r_en      = !rd_srst && !bus.fifo_empty && (level < (OCC_W+1)'(BUF_DEPTH));
    bus.frame_done     = frame_done_q;
    bus.frame_len      = frame_len_q;
    bus.frame_oversize = frame_oversize_q;
  end

  // Output buffer: capture returning read data at the tail, release from the head on pop.
  // Clearing inflight on reset drops any read whose data is still on its way back.
  always_ff @(posedge rclk) begin
    if (rd_srst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) buf_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= bus.fifo_r_en;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= bus.fifo_rdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({inflight_q, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Per-frame word counter with saturation; reports length/oversize the cycle after the last pop.
  always_ff @(posedge rclk) begin
    if (rd_srst) begin
      cnt_q            <= '0;
      sticky_q         <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_len_q      <= '0;
      frame_oversize_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (pop) begin
        if (bus.m_last) begin
          frame_done_q     <= 1'b1;
          frame_len_q      <= (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + LEN_W'(1);
          frame_oversize_q <= sticky_q | (cnt_q == CNT_MAX);
          cnt_q            <= '0;
          sticky_q         <= 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          sticky_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + LEN_W'(1);
        end
      end
    end
  end

  // The read-enable throttle must never let a capture land in a full buffer without a pop.
  buf_no_overflow: assert property (@(posedge rclk) disable iff (rd_srst)
    !(inflight_q && !pop && (occ_q == OCC_W'(BUF_DEPTH))));

endmodule
